// File: rtl/line_data_memory.sv
// Line-granular backing memory with a fixed access latency and one request in flight.
// Each accepted request reads or writes one full line of the array.
module line_data_memory #(
    parameter int NUM_LINES = 256,
    parameter int LINE_BITS = 128,
    parameter int DELAY     = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 is_input_valid,
    input  logic [31:0]          addr,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [LINE_BITS-1:0] din,
    output logic                 is_output_valid,
    output logic [LINE_BITS-1:0] dout,
    output logic                 mem_ready,
    output logic                 illegal_req,
    output logic [1:0]           state_dbg
);

    localparam int IW = $clog2(NUM_LINES);
    localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;

    // Handshake: a request transfers at a posedge where mem_ready and
    // is_input_valid are both high and exactly one of mem_read/mem_write is set.
    // The read response is valid for the single cycle is_output_valid is high.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          count_q;
    logic [IW-1:0]          index_q;
    logic [LINE_BITS-1:0]   din_q;
    logic                   op_write_q;
    logic [LINE_BITS-1:0]   mem [NUM_LINES];

    logic accept;
    logic done;
    logic both_ops;
    logic unused_addr_bits;

    assign mem_ready        = (state_q != BUSY);
    assign is_output_valid  = (state_q == RESP);
    assign state_dbg        = state_q;
    assign both_ops         = is_input_valid & mem_read & mem_write;
    assign accept           = mem_ready & is_input_valid & (mem_read ^ mem_write);
    assign done             = (state_q == BUSY) && (count_q == '0);
    assign unused_addr_bits = ^addr[31:IW];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BUSY;
            BUSY:    if (done) state_d = op_write_q ? IDLE : RESP;
            RESP:    state_d = accept ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            index_q     <= '0;
            din_q       <= '0;
            op_write_q  <= 1'b0;
            dout        <= '0;
            illegal_req <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                index_q    <= addr[IW-1:0];
                din_q      <= din;
                op_write_q <= mem_write;
                count_q    <= CW'(DELAY - 1);
            end else if (state_q == BUSY && count_q != '0) begin
                count_q <= count_q - CW'(1);
            end
            if (done && !op_write_q)
                dout <= mem[index_q];
            if (mem_ready && both_ops)
                illegal_req <= 1'b1;
        end
    end

    // Array has no reset; a reset on the completion edge drops the pending write.
    always_ff @(posedge clk) begin
        if (!reset && done && op_write_q)
            mem[index_q] <= din_q;
    end

endmodule
